crc9_128_dec: RTL

Receive-side checker for the crc9_128 encoder codeword: 137-bit code = 128 data bits followed by 9 CRC bits, index 0 transmitted first. Recomputes the remainder of the whole codeword serially, BPC bits per clock, then reports the data, the syndrome and an error flag. Sits after the link/storage path, feeding consumers through a valid/ready pair on each side.

---
 rtl/crc9_128_dec.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/crc9_128_dec.sv
// -----------------------------------------------------------------------------
// crc9_128_dec
//
// Receive-side checker for the 137-bit crc9_128 codeword (128 data bits
// followed by 9 CRC bits, code index 0 transmitted first / coefficient x^136).
// The whole codeword is divided by the generator BPC bits per clock, MSB
// first, with init 0, no reflection and no final XOR; a clean codeword leaves
// a zero remainder.
//
// Optional build macro: CRC9_DEC_CORRECT_EN
//   When defined, a nonzero syndrome triggers a single-bit error search.
//   A register walks the syndromes x^j mod P of every code index (136-j).
//   On a match, the offending data bit is flipped in o_data and o_corrected
//   is set. When undefined, o_corrected is tied low.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   enable       global clock enable; low freezes every register
//   i_code       [0:136] codeword, [0:127] data, [128:136] CRC
//   i_valid      input codeword valid
//   o_ready      block can accept a codeword (registered)
//   o_data       [0:127] data field of the accepted codeword
//   o_syndrome   9-bit remainder, bit 0 = x^0
//   o_err        syndrome nonzero
//   o_corrected  single-bit correction applied
//   o_valid      result valid
//   i_ready      consumer accepts the result
// -----------------------------------------------------------------------------
module crc9_128_dec #(
    parameter int         BPC  = 8,
    parameter logic [8:0] POLY = 9'h011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [0:136] i_code,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [0:127] o_data,
    output logic [8:0]   o_syndrome,
    output logic         o_err,
    output logic         o_corrected,
    output logic         o_valid,
    input  logic         i_ready
);

    localparam int N  = (137 + BPC - 1) / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        DONE   = 3'd2,
        SEARCH = 3'd3,
        FIX    = 3'd4
    } state_t;

    state_t          state_reg;
    logic [0:136]    sh_reg;
    logic [0:127]    data_reg;
    logic [8:0]      rem_reg;
    logic [CW-1:0]   cnt_reg;

    logic [8:0]      rem_next;
    logic            fb;
    logic            last_chunk;

    // Fold up to BPC bits of the codeword into the remainder. Bits past the
    // end of the codeword (partial last chunk) are skipped, so the remainder
    // always covers exactly 137 bits.
    always_comb begin
        rem_next = rem_reg;
        fb       = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (int'(cnt_reg) * BPC + i < 137) begin
                fb       = rem_next[8];
                rem_next = {rem_next[7:0], sh_reg[i]} ^ (fb ? POLY : 9'h000);
            end
        end
    end

    assign last_chunk = (cnt_reg == CW'(N - 1));

`ifdef CRC9_DEC_CORRECT_EN
    logic [8:0] s_reg;
    logic [7:0] j_reg;
    logic [7:0] flip_idx;
    logic       corrected_reg;
    logic [8:0] s_mulx;

    // s * x mod P
    assign s_mulx      = {s_reg[7:0], 1'b0} ^ (s_reg[8] ? POLY : 9'h000);
    // Step j corresponds to code index 136-j; only j >= 9 lands in data.
    assign flip_idx    = 8'd136 - j_reg;
    assign o_corrected = corrected_reg;
`else
    assign o_corrected = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            o_ready       <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_syndrome    <= '0;
            o_err         <= 1'b0;
            sh_reg        <= '0;
            data_reg      <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
`ifdef CRC9_DEC_CORRECT_EN
            s_reg         <= 9'h001;
            j_reg         <= '0;
            corrected_reg <= 1'b0;
`endif
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        sh_reg    <= i_code;
                        data_reg  <= i_code[0:127];
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        o_ready   <= 1'b0;
                        state_reg <= CALC;
                    end
                end

                CALC: begin
                    rem_reg <= rem_next;
                    sh_reg  <= sh_reg << BPC;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_chunk) begin
                        o_data     <= data_reg;
                        o_syndrome <= rem_next;
                        o_err      <= |rem_next;
`ifdef CRC9_DEC_CORRECT_EN
                        corrected_reg <= 1'b0;
                        if (|rem_next) begin
                            s_reg     <= 9'h001;
                            j_reg     <= '0;
                            state_reg <= SEARCH;
                        end else begin
                            o_valid   <= 1'b1;
                            state_reg <= DONE;
                        end
`else
                        o_valid   <= 1'b1;
                        state_reg <= DONE;
`endif
                    end
                end

`ifdef CRC9_DEC_CORRECT_EN
                SEARCH: begin
                    if (s_reg == o_syndrome) begin
                        corrected_reg <= 1'b1;
                        if (j_reg >= 8'd9) begin
                            o_data[flip_idx[6:0]] <= ~o_data[flip_idx[6:0]];
                        end
                        state_reg <= FIX;
                    end else begin
                        s_reg <= s_mulx;
                        j_reg <= j_reg + 8'd1;
                        // Every code index has been tried without a match.
                        if (j_reg == 8'd136) begin
                            state_reg <= FIX;
                        end
                    end
                end

                FIX: begin
                    o_valid   <= 1'b1;
                    state_reg <= DONE;
                end
`endif

                DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_ready   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
